// File: rtl/bmc_heartbeat_monitor.sv
// Qualifies the BMC heartbeat pin: synchronise, deglitch, measure rising-edge periods in ms
// and drive the alive/lost status consumed by the BIOS-failover state machine.
module bmc_heartbeat_monitor #(
  parameter int unsigned DEGLITCH_MS     = 5,
  parameter int unsigned PERIOD_MIN_MS   = 800,
  parameter int unsigned PERIOD_MAX_MS   = 1200,
  parameter int unsigned LOSS_TIMEOUT_MS = 3000,
  parameter int unsigned GOOD_CYCLES     = 3,
  parameter int unsigned CNT_W           = 12
) (
  input  logic             clk,
  input  logic             rst_l,
  input  logic             ms_tick,
  input  logic             monitor_en,
  input  logic             clr_stats,
  input  logic             hb_in,
  output logic             alive,
  output logic             lost,
  output logic             hb_edge_pulse,
  output logic [CNT_W-1:0] period_ms,
  output logic [7:0]       bad_cnt,
  output logic [1:0]       state
);

  localparam int unsigned RunW  = $clog2(DEGLITCH_MS + 1);
  localparam int unsigned GoodW = $clog2(GOOD_CYCLES + 1);

  localparam logic [RunW-1:0]  RunLast     = RunW'(DEGLITCH_MS - 1);
  localparam logic [GoodW-1:0] GoodLast    = GoodW'(GOOD_CYCLES - 1);
  localparam logic [CNT_W-1:0] PeriodMin   = CNT_W'(PERIOD_MIN_MS);
  localparam logic [CNT_W-1:0] PeriodMax   = CNT_W'(PERIOD_MAX_MS);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOSS_TIMEOUT_MS - 1);

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StAcquire = 2'd1,
    StAlive   = 2'd2,
    StLost    = 2'd3
  } state_e;

  logic             sync1_q, sync2_q;
  logic             filt_q, filt_d;
  logic [RunW-1:0]  run_q, run_d;
  logic             edge_q, edge_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic [7:0]       bad_q, bad_d;
  logic [GoodW-1:0] good_q, good_d;
  logic             first_q, first_d;
  state_e           state_q, state_d;

  logic             period_good;
  logic             bad_inc;

  // Deglitch: the filtered level follows only after DEGLITCH_MS consecutive mismatching ticks.
  always_comb begin
    filt_d = filt_q;
    run_d  = run_q;
    if (ms_tick) begin
      if (sync2_q == filt_q) begin
        run_d = '0;
      end else if (run_q == RunLast) begin
        filt_d = ~filt_q;
        run_d  = '0;
      end else begin
        run_d = run_q + 1'b1;
      end
    end
  end

  assign edge_d      = filt_d & ~filt_q;
  assign period_good = (cnt_q >= PeriodMin) && (cnt_q <= PeriodMax);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    good_d   = good_q;
    first_d  = first_q;
    bad_inc  = 1'b0;

    if (!monitor_en) begin
      state_d = StIdle;
      cnt_d   = '0;
      good_d  = '0;
      first_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StAcquire;
          cnt_d   = '0;
          good_d  = '0;
          first_d = 1'b0;
        end
        default: begin
          // An edge owns its cycle: the period is captured and the counter restarts.
          if (edge_q) begin
            period_d = cnt_q;
            cnt_d    = '0;
            if (state_q == StAlive) begin
              if (!period_good) begin
                state_d = StLost;
                good_d  = '0;
                bad_inc = 1'b1;
              end
            end else if (!first_q) begin
              first_d = 1'b1;
            end else if (period_good) begin
              if (good_q == GoodLast) begin
                state_d = StAlive;
                good_d  = '0;
              end else begin
                good_d = good_q + 1'b1;
              end
            end else begin
              good_d  = '0;
              bad_inc = 1'b1;
            end
          end else if (ms_tick) begin
            if (cnt_q != '1) begin
              cnt_d = cnt_q + 1'b1;
            end
            // Once LOST, further silence is not counted again.
            if ((cnt_q == TimeoutLast) && (state_q != StLost)) begin
              state_d = StLost;
              good_d  = '0;
              first_d = 1'b1;
              bad_inc = 1'b1;
            end
          end
        end
      endcase
    end
  end

  always_comb begin
    bad_d = bad_q;
    if (clr_stats) begin
      bad_d = '0;
    end else if (bad_inc && (bad_q != 8'hFF)) begin
      bad_d = bad_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      filt_q   <= 1'b0;
      run_q    <= '0;
      edge_q   <= 1'b0;
      cnt_q    <= '0;
      period_q <= '0;
      bad_q    <= '0;
      good_q   <= '0;
      first_q  <= 1'b0;
      state_q  <= StIdle;
    end else begin
      sync1_q  <= hb_in;
      sync2_q  <= sync1_q;
      filt_q   <= filt_d;
      run_q    <= run_d;
      edge_q   <= edge_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      bad_q    <= bad_d;
      good_q   <= good_d;
      first_q  <= first_d;
      state_q  <= state_d;
    end
  end

  assign alive         = (state_q == StAlive);
  assign lost          = (state_q == StLost);
  assign state         = state_q;
  assign hb_edge_pulse = edge_q;
  assign period_ms     = period_q;
  assign bad_cnt       = bad_q;

endmodule

// File: tb/tb_bmc_heartbeat_monitor.sv
// Bench for bmc_heartbeat_monitor: heartbeat waveforms built from period lists, checked against
// an event-level model of the alive/lost rules.
module tb_bmc_heartbeat_monitor;

  logic        clk, rst_l, ms_tick, monitor_en, clr_stats, hb_in;
  logic        alive, lost, hb_edge_pulse;
  logic [11:0] period_ms;
  logic [7:0]  bad_cnt;
  logic [1:0]  state;

  int n_chk, n_pass, pulse_cnt, el;
  int m_state, m_good, m_bad, m_period;
  bit m_first;
  logic [23:0] obs_v, exp_v;

  bmc_heartbeat_monitor dut (
    .clk           (clk),
    .rst_l         (rst_l),
    .ms_tick       (ms_tick),
    .monitor_en    (monitor_en),
    .clr_stats     (clr_stats),
    .hb_in         (hb_in),
    .alive         (alive),
    .lost          (lost),
    .hb_edge_pulse (hb_edge_pulse),
    .period_ms     (period_ms),
    .bad_cnt       (bad_cnt),
    .state         (state)
  );

  assign obs_v = {alive, lost, state, bad_cnt, period_ms};

  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // One-clk ms_tick every second clock keeps the run short.
  initial begin
    ms_tick = 1'b0;
    forever begin
      @(negedge clk) ms_tick = 1'b1;
      @(negedge clk) ms_tick = 1'b0;
    end
  end

  always @(negedge clk) if (hb_edge_pulse === 1'b1) pulse_cnt++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- reference model (event level) ----------------
  function automatic void model_bump();
    if (m_bad < 255) m_bad++;
  endfunction

  function automatic void model_timeout();
    if (m_state == 1 || m_state == 2) begin
      m_state = 3;
      m_good  = 0;
      m_first = 1'b1;
      model_bump();
    end
  endfunction

  function automatic void model_edge(input int p);
    bit good;
    if (m_state == 0) return;
    m_period = (p > 4095) ? 4095 : p;
    if (p >= 3000) model_timeout();
    good = (m_period >= 800) && (m_period <= 1200);
    if (m_state == 2) begin
      if (!good) begin
        m_state = 3;
        model_bump();
      end
    end else if (!m_first) begin
      m_first = 1'b1;
    end else if (good) begin
      m_good++;
      if (m_good == 3) begin
        m_state = 2;
        m_good  = 0;
      end
    end else begin
      m_good = 0;
      model_bump();
    end
  endfunction

  // ---------------- stimulus primitives ----------------
  task automatic tick_wait(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (ms_tick !== 1'b1);
    end
    el += n;
    #1;
  endtask

  task automatic enable_mon();
    monitor_en = 1'b1;
    el = 0;
    m_state = 1;
    m_good = 0;
    m_first = 1'b0;
  endtask

  task automatic disable_mon();
    monitor_en = 1'b0;
    m_state = 0;
    m_good = 0;
    m_first = 1'b0;
  endtask

  // Raw rise; the filtered edge lands 6 ticks later, so 8 ticks in the edge is settled.
  task automatic rise();
    hb_in = 1'b1;
    tick_wait(8);
    model_edge(el - 2);
    el = 2;
  endtask

  task automatic fall_rest(input int p, input bit glitch);
    int h = p / 2;
    tick_wait(h - 8);
    hb_in = 1'b0;
    if (glitch) begin
      tick_wait(100);
      hb_in = 1'b1;
      tick_wait(3);
      hb_in = 1'b0;
      tick_wait(p - h - 103);
    end else begin
      tick_wait(p - h);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_l = 1'b0; monitor_en = 1'b0; clr_stats = 1'b0; hb_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    n_chk++;
    if (obs_v !== 24'h0) $display("FAIL reset_outputs: got %h want %h", obs_v, 24'h0);
    else n_pass++;
    n_chk++;
    if (hb_edge_pulse !== 1'b0) $display("FAIL reset_pulse: got %b want 0", hb_edge_pulse);
    else n_pass++;
    @(negedge clk) rst_l = 1'b1;
    tick_wait(1);
  endtask

  task automatic test_acquire();
    enable_mon();
    tick_wait(10);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) fall_rest(1000, 1'b0);
      rise();
      exp_v = {m_state == 2, m_state == 3, 2'(m_state), 8'(m_bad), 12'(m_period)};
      n_chk++;
      if (obs_v !== exp_v) $display("FAIL acquire_%0d: got %h want %h", i, obs_v, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_glitch();
    for (int i = 0; i < 2; i++) begin
      int pc0 = pulse_cnt;
      fall_rest(1000, 1'b1);
      rise();
      exp_v = {m_state == 2, m_state == 3, 2'(m_state), 8'(m_bad), 12'(m_period)};
      n_chk++;
      if (obs_v !== exp_v) $display("FAIL glitch_%0d: got %h want %h", i, obs_v, exp_v);
      else n_pass++;
      n_chk++;
      if (pulse_cnt - pc0 !== 1) $display("FAIL glitch_pulses_%0d: got %0d want 1", i, pulse_cnt - pc0);
      else n_pass++;
    end
  endtask

  task automatic test_periods(input string name, input int p0, input int p1, input int p2,
                              input int p3, input int p4, input int n);
    int plist[5] = '{p0, p1, p2, p3, p4};
    for (int i = 0; i < n; i++) begin
      fall_rest(plist[i], 1'b0);
      rise();
      exp_v = {m_state == 2, m_state == 3, 2'(m_state), 8'(m_bad), 12'(m_period)};
      n_chk++;
      if (obs_v !== exp_v) $display("FAIL %s_%0d: got %h want %h", name, i, obs_v, exp_v);
      else n_pass++;
    end
  endtask

  task automatic test_bad_period();
    test_periods("bad_period", 1500, 1000, 1000, 1000, 0, 4);
  endtask

  task automatic test_random();
    for (int i = 0; i < 4; i++) begin
      int cat = int'($urandom_range(0, 2));
      int p = (cat == 0) ? int'($urandom_range(800, 1200)) :
              (cat == 1) ? int'($urandom_range(300, 799)) : int'($urandom_range(1201, 2000));
      fall_rest(p, 1'b0);
      rise();
      exp_v = {m_state == 2, m_state == 3, 2'(m_state), 8'(m_bad), 12'(m_period)};
      n_chk++;
      if (obs_v !== exp_v) $display("FAIL random_%0d p=%0d: got %h want %h", i, p, obs_v, exp_v);
      else n_pass++;
    end
    test_periods("recover", 1000, 1000, 1000, 0, 0, 3);
  endtask

  task automatic test_disable();
    disable_mon();
    @(posedge clk);
    #1;
    exp_v = {1'b0, 1'b0, 2'd0, 8'(m_bad), 12'(m_period)};
    n_chk++;
    if (obs_v !== exp_v) $display("FAIL disable: got %h want %h", obs_v, exp_v);
    else n_pass++;
  endtask

  task automatic test_acquire_seq();
    hb_in = 1'b0;
    tick_wait(20);
    enable_mon();
    tick_wait(10);
    rise();
    exp_v = {m_state == 2, m_state == 3, 2'(m_state), 8'(m_bad), 12'(m_period)};
    n_chk++;
    if (obs_v !== exp_v) $display("FAIL acq_seq_start: got %h want %h", obs_v, exp_v);
    else n_pass++;
    test_periods("acq_seq", 1000, 700, 1000, 1000, 1000, 5);
  endtask

  task automatic test_timeout();
    tick_wait(492);
    hb_in = 1'b0;
    tick_wait(2999 - el);
    exp_v = {m_state == 2, m_state == 3, 2'(m_state), 8'(m_bad), 12'(m_period)};
    n_chk++;
    if (obs_v !== exp_v) $display("FAIL timeout_before: got %h want %h", obs_v, exp_v);
    else n_pass++;
    tick_wait(1);
    model_timeout();
    exp_v = {m_state == 2, m_state == 3, 2'(m_state), 8'(m_bad), 12'(m_period)};
    n_chk++;
    if (obs_v !== exp_v) $display("FAIL timeout_at: got %h want %h", obs_v, exp_v);
    else n_pass++;
    tick_wait(1500);
    n_chk++;
    if (obs_v !== exp_v) $display("FAIL timeout_hold: got %h want %h", obs_v, exp_v);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    disable_mon();
    tick_wait(20);
    enable_mon();
    tick_wait(10);
    rise();
    exp_v = {m_state == 2, m_state == 3, 2'(m_state), 8'(m_bad), 12'(m_period)};
    n_chk++;
    if (obs_v !== exp_v) $display("FAIL reset_mid_pre: got %h want %h", obs_v, exp_v);
    else n_pass++;
    tick_wait(20);
    #5;
    rst_l = 1'b0;
    #1;
    n_chk++;
    if ({obs_v, hb_edge_pulse} !== 25'h0) begin
      $display("FAIL reset_mid: got %h want %h", {obs_v, hb_edge_pulse}, 25'h0);
    end else n_pass++;
    disable_mon();
    m_bad = 0;
    m_period = 0;
    hb_in = 1'b0;
    @(negedge clk) rst_l = 1'b1;
    tick_wait(20);
    n_chk++;
    if (obs_v !== 24'h0) $display("FAIL reset_mid_after: got %h want %h", obs_v, 24'h0);
    else n_pass++;
  endtask

  task automatic test_boundary();
    enable_mon();
    tick_wait(10);
    rise();
    test_periods("boundary", 800, 1200, 800, 1201, 799, 5);
  endtask

  task automatic test_saturate();
    hb_in = 1'b0;
    tick_wait(20);
    for (int i = 0; i < 260; i++) begin
      hb_in = 1'b1;
      tick_wait(6);
      model_edge(el);
      el = 0;
      hb_in = 1'b0;
      tick_wait(6);
    end
    exp_v = {m_state == 2, m_state == 3, 2'(m_state), 8'(m_bad), 12'(m_period)};
    n_chk++;
    if (obs_v !== exp_v) $display("FAIL saturate: got %h want %h", obs_v, exp_v);
    else n_pass++;
    clr_stats = 1'b1;
    @(posedge clk);
    #1;
    clr_stats = 1'b0;
    m_bad = 0;
    exp_v = {m_state == 2, m_state == 3, 2'(m_state), 8'(m_bad), 12'(m_period)};
    n_chk++;
    if (obs_v !== exp_v) $display("FAIL clr_stats: got %h want %h", obs_v, exp_v);
    else n_pass++;
  endtask

  initial begin
    n_chk = 0; n_pass = 0; pulse_cnt = 0; el = 0;
    m_state = 0; m_good = 0; m_bad = 0; m_period = 0; m_first = 1'b0;
    test_reset();
    test_acquire();
    test_glitch();
    test_bad_period();
    test_random();
    test_disable();
    test_acquire_seq();
    test_timeout();
    test_reset_mid();
    test_boundary();
    test_saturate();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
